alu_multiword_sequencer: RTL and testbench
==========================================

# alu_multiword_sequencer

Sequences the combinational 16-bit `alu` over several machine words, so one request performs a WORDS×16-bit ADD/SUB/AND/OR/XOR/NOP. The carry/borrow is chained from the least-significant word upward. The block instantiates one `alu` internally and drives it one word per clock. It sits between the micro-alpha control unit, or any wide-arithmetic requester, and the ALU. Requests and responses each use a valid/ready handshake.

## Interface
- WORDS, 2, number of 16-bit words per operand (≥1; default gives 32-bit operations)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_op  input  ALU_OPERATION  operation, from package_alu
- req_left  input  WORDS*16  left operand, word 0 = bits [15:0]
- req_right  input  WORDS*16  right operand
- req_cin  input  1  initial carry (ADD) or borrow (SUB)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_result  output  WORDS*16  result
- rsp_cout  output  1  final carry (ADD) or borrow (SUB); 0 for logic ops and NOP
- rsp_zero  output  1  high when rsp_result == 0

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - req_ready=1, rsp_valid=0.
  - On req_valid&req_ready: latch op, left and right; clear the word index; go to RUN.
  - Carry register loads req_cin for ADD/SUB and 0 for AND/OR/XOR/NOP.
- **RUN**
  - Drive `alu` with latched op, left/right word[index] and the carry register.
  - Each edge: result word[index] ← alu result; carry ← alu cout; index++.
  - After the edge that writes word WORDS-1, go to DONE.
- **DONE**
  - rsp_valid=1. rsp_result and rsp_cout = result register and carry register.
  - On rsp_valid&rsp_ready, go to IDLE.
- **Arithmetic:** ALU semantics per word.
  - ADD: word = l+r+c mod 2^16, carry out on overflow.
  - SUB: word = l−r−c mod 2^16, borrow out on underflow.
  - Logic ops: cout=0.
  - NOP: word = 16'hFFFF, cout=0.
- rsp_zero is the combinational NOR of rsp_result. It is only meaningful while rsp_valid=1.
- req_* inputs are ignored outside IDLE. Requesters must hold them stable only until accepted.
- Index width is max(1, $clog2(WORDS)). WORDS=1 is legal: one RUN cycle.
- **Reset (any state, including mid-RUN or DONE):** state←IDLE, index←0, carry←0, result←0, latched operands←0.
  - Reset outputs: req_ready=1, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=1.
  - An in-flight operation is discarded, with no response.

## Timing
- Accept edge E0. RUN occupies the WORDS cycles that follow E0.
- rsp_valid rises in the cycle after edge E_WORDS, which is exactly WORDS cycles after E0.
- The response handshake edge returns the block to IDLE. req_ready is high in the next cycle.
- Minimum request-to-request period is WORDS+2 cycles. There is no overlap of operations.
- rsp_result, rsp_cout and rsp_zero are registered. They stay stable while rsp_valid=1 and rsp_ready=0, for any number of cycles.
- req_ready=0 from the cycle after E0 until the cycle after the response handshake.
- There is no combinational path from req_* or rsp_ready to any output.

## Test plan
- ADD with cross-word carry, WORDS=2: left=32'h0000FFFF, right=32'h00000001, cin=0 -> result=32'h00010000, cout=0, zero=0. rsp_valid exactly 2 cycles after accept.
- ADD overflow:
  - left=32'hFFFFFFFF, right=0, cin=1 -> result=0, cout=1, zero=1.
  - left=32'hFFFFFFF3, right=32'h0000000E, cin=1 -> result=32'h00000002, cout=1.
- SUB borrow chain:
  - 32'h00010000−32'h00000001, cin=0 -> 32'h0000FFFF, cout=0.
  - 32'd3−32'd7, cin=1 -> 32'hFFFFFFFB, cout=1.
- Logic ops and NOP with req_cin=1 (cin must be ignored):
  - XOR 32'hFFFF0000^32'h5A5A5A5A -> 32'hA5A55A5A, cout=0.
  - AND 32'hFAFAFAFA&32'h5F5F5F5F -> 32'h5A5A5A5A.
  - NOP -> 32'hFFFFFFFF, cout=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* must stay stable and req_ready=0.
  - A second req_valid pulse with different operands is ignored.
  - After rsp_ready=1, req_ready rises the next cycle and the second request completes correctly.
- Reset mid-RUN: assert rst_n=0 one cycle after accept.
  - Outputs immediately (asynchronously) show req_ready=1, rsp_valid=0, rsp_result=0, rsp_cout=0.
  - After release, a new ADD 20+32 completes with result 52.

Source files
------------

// File: rtl/alu_multiword_sequencer.sv
// Multi-word ALU sequencer: runs one 16-bit ALU over WORDS words per request,
// chaining carry/borrow from the least-significant word upward.

package package_alu;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOP = 3'd5
   } ALU_OPERATION;
endpackage

// Combinational 16-bit ALU slice with carry/borrow in and out.
module alu
   import package_alu::*;
(
   input  ALU_OPERATION op,
   input  logic [15:0]  left,
   input  logic [15:0]  right,
   input  logic         cin,
   output logic [15:0]  result,
   output logic         cout
);
   logic [16:0] sum_w;

   // Word-level operation; SUB reports a borrow through bit 16 of the wrapped difference.
   always_comb begin
      sum_w  = '0;
      result = 16'hFFFF;
      cout   = 1'b0;
      case (op)
         ALU_ADD: begin
            sum_w  = {1'b0, left} + {1'b0, right} + {16'b0, cin};
            result = sum_w[15:0];
            cout   = sum_w[16];
         end
         ALU_SUB: begin
            sum_w  = {1'b0, left} - {1'b0, right} - {16'b0, cin};
            result = sum_w[15:0];
            cout   = sum_w[16];
         end
         ALU_AND: result = left & right;
         ALU_OR:  result = left | right;
         ALU_XOR: result = left ^ right;
         default: result = 16'hFFFF;
      endcase
   end
endmodule

module alu_multiword_sequencer
   import package_alu::*;
#(
   parameter int WORDS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  ALU_OPERATION       req_op,
   input  logic [WORDS*16-1:0] req_left,
   input  logic [WORDS*16-1:0] req_right,
   input  logic               req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WORDS*16-1:0] rsp_result,
   output logic               rsp_cout,
   output logic               rsp_zero
);
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic         carry_q, carry_d;
   ALU_OPERATION op_q, op_d;

   logic [15:0]  left_w   [WORDS];
   logic [15:0]  right_w  [WORDS];
   logic [15:0]  alu_left, alu_right, alu_result;
   logic         alu_cout;
   logic         accept;
   logic         last_word;

   assign accept    = (state_q == S_IDLE) && req_valid;
   assign last_word = (idx_q == IW'(WORDS - 1));
   assign alu_left  = left_w[idx_q];
   assign alu_right = right_w[idx_q];

   alu u_alu (
      .op     (op_q),
      .left   (alu_left),
      .right  (alu_right),
      .cin    (carry_q),
      .result (alu_result),
      .cout   (alu_cout)
   );

   // Next-state, index and carry-chain control.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_RUN;
               idx_d   = '0;
               op_d    = req_op;
               // Logic ops and NOP must not see the requester's carry-in.
               carry_d = ((req_op == ALU_ADD) || (req_op == ALU_SUB)) ? req_cin : 1'b0;
            end
         end
         S_RUN: begin
            carry_d = alu_cout;
            if (last_word) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= ALU_ADD;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_q    <= op_d;
      end
   end

   // Per-word operand latches and result storage.
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [15:0] left_q, left_d;
      logic [15:0] right_q, right_d;
      logic [15:0] result_q, result_d;

      // Capture operands on accept; write this word when the index reaches it.
      always_comb begin
         left_d   = left_q;
         right_d  = right_q;
         result_d = result_q;
         if (accept) begin
            left_d  = req_left[gi*16 +: 16];
            right_d = req_right[gi*16 +: 16];
         end
         if ((state_q == S_RUN) && (idx_q == IW'(gi))) begin
            result_d = alu_result;
         end
      end

      // Word storage registers.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            left_q   <= '0;
            right_q  <= '0;
            result_q <= '0;
         end else begin
            left_q   <= left_d;
            right_q  <= right_d;
            result_q <= result_d;
         end
      end

      assign left_w[gi]              = left_q;
      assign right_w[gi]             = right_q;
      assign rsp_result[gi*16 +: 16] = result_q;
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_cout  = carry_q;
   assign rsp_zero  = ~|rsp_result;

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Scoreboard bench for alu_multiword_sequencer with WORDS=2 directed vectors.
module tb_alu_multiword_sequencer;
   import package_alu::*;

   localparam int WORDS = 2;
   localparam int W     = WORDS * 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   ALU_OPERATION req_op = ALU_ADD;
   logic [W-1:0] req_left = '0;
   logic [W-1:0] req_right = '0;
   logic         req_cin = 1'b0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_result;
   logic         rsp_cout;
   logic         rsp_zero;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         zero;
      string        name;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_multiword_sequencer #(.WORDS(WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_left   (req_left),
      .req_right  (req_right),
      .req_cin    (req_cin),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .rsp_zero   (rsp_zero)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response handshake.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rsp", 1'b1, 1'b0);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, "_result"}, rsp_result, mon_e.res);
            check({mon_e.name, "_cout"}, W'(rsp_cout), W'(mon_e.cout));
            check({mon_e.name, "_zero"}, W'(rsp_zero), W'(mon_e.zero));
            $display("rsp %-10s result=%h cout=%0d zero=%0d", mon_e.name, rsp_result, rsp_cout, rsp_zero);
         end
      end
   end

   // Called at posedge+1; returns at accept edge+1.
   task automatic issue(input ALU_OPERATION op, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic c, input logic [W-1:0] er, input logic ec,
                        input string nm, input bit push);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_req_ready"}, W'(req_ready), W'(1));
      req_op    = op;
      req_left  = l;
      req_right = r;
      req_cin   = c;
      req_valid = 1'b1;
      if (push) sb_q.push_back('{er, ec, (er == '0), nm});
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_op(input ALU_OPERATION op, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic c, input logic [W-1:0] er, input logic ec, input string nm);
      int cyc;
      issue(op, l, r, c, er, ec, nm, 1'b1);
      wait_valid(cyc);
      check({nm, "_latency"}, W'(cyc), W'(WORDS));
      @(posedge clk); #1;
      check({nm, "_ready_after"}, W'(req_ready), W'(1));
   endtask

   initial begin
      int cyc;
      #2;
      check("rst_req_ready", W'(req_ready), W'(1));
      check("rst_rsp_valid", W'(rsp_valid), W'(0));
      check("rst_result", rsp_result, '0);
      check("rst_cout", W'(rsp_cout), W'(0));
      check("rst_zero", W'(rsp_zero), W'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, "add_carry");
      run_op(ALU_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, "add_ovf0");
      run_op(ALU_ADD, 32'hFFFFFFF3, 32'h0000000E, 1'b1, 32'h00000002, 1'b1, "add_ovf1");
      run_op(ALU_SUB, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, "sub_chain");
      run_op(ALU_SUB, 32'd3,        32'd7,        1'b1, 32'hFFFFFFFB, 1'b1, "sub_borrow");
      run_op(ALU_XOR, 32'hFFFF0000, 32'h5A5A5A5A, 1'b1, 32'hA5A55A5A, 1'b0, "xor");
      run_op(ALU_AND, 32'hFAFAFAFA, 32'h5F5F5F5F, 1'b1, 32'h5A5A5A5A, 1'b0, "and");
      run_op(ALU_NOP, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hFFFFFFFF, 1'b0, "nop");

      // Backpressure: response held for 5 cycles while a stray request pulses.
      rsp_ready = 1'b0;
      issue(ALU_OR, 32'h12340000, 32'h00005678, 1'b1, 32'h12345678, 1'b0, "bp_or", 1'b1);
      wait_valid(cyc);
      check("bp_latency", W'(cyc), W'(WORDS));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_result", rsp_result, 32'h12345678);
         check("bp_hold_cout", W'(rsp_cout), W'(0));
         check("bp_hold_valid", W'(rsp_valid), W'(1));
         check("bp_req_ready", W'(req_ready), W'(0));
         if (i == 1) begin
            req_op    = ALU_ADD;
            req_left  = 32'h11111111;
            req_right = 32'h22222222;
            req_cin   = 1'b0;
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_rise", W'(req_ready), W'(1));
      run_op(ALU_ADD, 32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, "bp_second");

      // Reset one cycle into RUN discards the operation.
      issue(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, '0, 1'b0, "aborted", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", W'(req_ready), W'(1));
      check("midrst_rsp_valid", W'(rsp_valid), W'(0));
      check("midrst_result", rsp_result, '0);
      check("midrst_cout", W'(rsp_cout), W'(0));
      check("midrst_zero", W'(rsp_zero), W'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(ALU_ADD, 32'd20, 32'd32, 1'b0, 32'd52, 1'b0, "add_post_rst");

      repeat (2) @(posedge clk);
      #1;
      check("sb_empty", W'(sb_q.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
